axi_burst_exerciser: RTL
========================

// Module: axi_burst_exerciser
// PURPOSE
//  AXI4 master traffic generator that drives the simulated PCIe slave model in testbenches.
//  Issues a programmed run of INCR write bursts, then read bursts over the same region.
//  Write data and expected read data both use the address pattern: each beat = {DW/64{beat_addr[63:0]}}.
//  Checks every response and reports busy, done and error status.
// PARAMETERS
//  DW        512  data width in bits; multiple of 64
//  AW        64   address width
//  IW        4    ID width; all IDs driven 0
//  MAX_OUTST 4    maximum read bursts in flight (AR accepted, RLAST not yet received); 1..15
// PORTS
//  clk          in   1      clock
//  resetn       in   1      synchronous active-low reset
//  start        in   1      1-cycle pulse; begins a run; ignored while busy
//  base_addr    in   AW     start address of burst 0
//  burst_len    in   8      AxLEN for every burst (beats = burst_len+1)
//  burst_count  in   16     bursts per phase
//  do_write     in   1      run write phase
//  do_read      in   1      run read phase
//  busy         out  1      high from the cycle after start until done
//  done         out  1      1-cycle pulse at end of run
//  err_count    out  16     mismatch/bad-response count; saturates at 16'hFFFF
//  cycle_count  out  32     cycles start->done (EXER_CYCLE_COUNT_EN only)
//  M_AXI_AW*    out  -      AWADDR[AW] AWLEN[8] AWSIZE[3] AWBURST[2] AWID[IW] AWLOCK AWCACHE[4] AWQOS[4] AWPROT[3] AWVALID; AWREADY in
//  M_AXI_W*     out  -      WDATA[DW] WSTRB[DW/8] WLAST WVALID; WREADY in
//  M_AXI_B*     mix  -      BRESP[2] in, BVALID in, BREADY out
//  M_AXI_AR*    out  -      ARADDR ARLEN ARSIZE ARBURST ARID ARLOCK ARCACHE ARQOS ARPROT ARVALID; ARREADY in
//  M_AXI_R*     mix  -      RDATA[DW] RRESP[2] RLAST RVALID in; RREADY out
// BEHAVIOUR
//  Reset: all VALIDs 0, BREADY=RREADY=0, busy=0, done=0, err_count=0, cycle_count=0; FSM->IDLE.
//  Reset mid-run: same values on the next edge; the bench also resets the slave.
//  Constants: SIZE=log2(DW/8), BURST=2'b01, ID/LOCK/CACHE/QOS/PROT=0, WSTRB=all ones.
//  Burst i address: base + i*(burst_len+1)*(DW/8), modulo 2^AW; beat k adds k*(DW/8). No 4KB check.
//  FSM: IDLE -> (start) latch inputs; err_count cleared; busy=1
//    -> WR_AW if do_write && burst_count!=0
//    -> else RD if do_read && burst_count!=0
//    -> else FIN (done pulses 2 cycles after start)
//  WR_AW: AWVALID held until AWREADY -> WR_W.
//  WR_W: WVALID held; beat advances on WREADY; WLAST on beat burst_len.
//    Last beat of last burst -> WR_B; otherwise -> WR_AW with next address.
//  BREADY=1 throughout the write phase; each B handshake counted.
//    BRESP!=0 -> err_count+1.
//  WR_B: wait until B count == burst_count -> RD (if do_read) else FIN.
//    B responses may arrive before WR_B is entered.
//  RD: AR issuer and R checker run concurrently.
//    ARVALID asserted while bursts remain && outst<MAX_OUTST.
//    outst +1 on AR handshake, -1 on R handshake with RLAST; both in one cycle -> unchanged.
//    RREADY=1 in RD. Each R beat checks RDATA==pattern, RRESP==0, RLAST==(beat==burst_len).
//    Any failure -> err_count+1, at most once per beat.
//    Expected-address tracker advances per beat, independent of the AR issuer.
//    All bursts received and outst==0 -> FIN.
//  FIN: done=1 for one cycle, busy=0 -> IDLE.
//  Stray R/B beats in IDLE are ignored (READY=0).
// CONFIGURATION
//  EXER_CYCLE_COUNT_EN defined:
//    cycle_count clears on start, increments every busy cycle, holds after done until the next start.
//  Not defined: cycle_count tied to 0, counter logic absent.
// TESTING
//  1. DW=512, base=0x1000, len=3, count=2, wr+rd
//     -> AW at 0x1000, 0x1100; 8 W beats; 2 B; AR at 0x1000, 0x1100; err_count=0; one done pulse.
//  2. Same run with RDATA bit 0 of beat 5 forced flipped -> err_count=1.
//  3. count=0, start -> no AXI VALIDs; done pulses 2 cycles after start.
//  4. count=8, MAX_OUTST=4, slave delays R by 50 cycles
//     -> exactly 4 AR handshakes before first RLAST; err_count=0.
//  5. Slave returns BRESP=2'b10 on burst 1 of count=3 -> err_count=1; read phase still runs.
//  6. resetn low 1 cycle during RD -> next cycle ARVALID=RREADY=0, busy=0; new start runs cleanly.

Source files
------------

// File: rtl/axi_burst_exerciser.sv
// AXI4 master burst exerciser: writes a run of INCR bursts with an address-derived data
// pattern, reads the same region back, and counts data/response errors.
// Optional build macro: EXER_CYCLE_COUNT_EN enables the start-to-done cycle counter.
module axi_burst_exerciser #(
    parameter int unsigned DW        = 512,
    parameter int unsigned AW        = 64,
    parameter int unsigned IW        = 4,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [7:0]      burst_len,
    input  logic [15:0]     burst_count,
    input  logic            do_write,
    input  logic            do_read,
    output logic            busy,
    output logic            done,
    output logic [15:0]     err_count,
    output logic [31:0]     cycle_count,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic [IW-1:0]   M_AXI_AWID,
    output logic            M_AXI_AWLOCK,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [3:0]      M_AXI_AWQOS,
    output logic [2:0]      M_AXI_AWPROT,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY,
    output logic [AW-1:0]   M_AXI_ARADDR,
    output logic [7:0]      M_AXI_ARLEN,
    output logic [2:0]      M_AXI_ARSIZE,
    output logic [1:0]      M_AXI_ARBURST,
    output logic [IW-1:0]   M_AXI_ARID,
    output logic            M_AXI_ARLOCK,
    output logic [3:0]      M_AXI_ARCACHE,
    output logic [3:0]      M_AXI_ARQOS,
    output logic [2:0]      M_AXI_ARPROT,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RLAST,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY
);

    localparam int unsigned Bytes   = DW / 8;
    localparam int unsigned Size    = $clog2(Bytes);
    localparam logic [AW-1:0] BeatInc = AW'(Bytes);
    localparam logic [3:0]  MaxOut  = 4'(MAX_OUTST);

    typedef enum logic [2:0] {StIdle, StInit, StWrAw, StWrW, StWrB, StRd, StFin} state_e;

    state_e          state_q, state_d;
    logic [7:0]      len_q;
    logic [15:0]     count_q;
    logic            do_write_q, do_read_q;
    logic [AW-1:0]   stride_q;
    logic [AW-1:0]   wr_addr_q;   // address of the current W beat (= next AWADDR between bursts)
    logic [7:0]      w_beat_q;
    logic [15:0]     w_burst_q;
    logic [15:0]     b_cnt_q;
    logic [AW-1:0]   ar_addr_q;
    logic [15:0]     ar_idx_q;
    logic [3:0]      outst_q;
    logic [AW-1:0]   r_addr_q;    // expected address of the next R beat
    logic [7:0]      r_beat_q;
    logic [15:0]     r_done_q;
    logic [15:0]     err_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_hs;
    logic w_last_beat, r_bad, err_inc, start_ok;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {(DW/64){64'(a)}};
    endfunction

    assign start_ok    = (state_q == StIdle) && start;
    assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs        = M_AXI_BVALID && M_AXI_BREADY;
    assign ar_hs       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs        = M_AXI_RVALID && M_AXI_RREADY;
    assign r_last_hs   = r_hs && M_AXI_RLAST;
    assign w_last_beat = (w_beat_q == len_q);

    // A beat counts at most one error however many of its checks fail.
    assign r_bad   = (M_AXI_RDATA != pattern(r_addr_q)) || (M_AXI_RRESP != 2'b00) ||
                     (M_AXI_RLAST != (r_beat_q == len_q));
    assign err_inc = (b_hs && (M_AXI_BRESP != 2'b00)) || (r_hs && r_bad);

    // Constant attributes and datapath-derived outputs.
    assign M_AXI_AWADDR  = wr_addr_q;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = 3'(Size);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'd0;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWPROT  = 3'd0;
    assign M_AXI_WDATA   = pattern(wr_addr_q);
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_last_beat;
    assign M_AXI_ARADDR  = ar_addr_q;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARSIZE  = 3'(Size);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign err_count     = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StInit;
            StInit: begin
                if (do_write_q && count_q != 16'd0)     state_d = StWrAw;
                else if (do_read_q && count_q != 16'd0) state_d = StRd;
                else                                    state_d = StFin;
            end
            StWrAw: if (M_AXI_AWREADY) state_d = StWrW;
            StWrW: begin
                if (M_AXI_WREADY && w_last_beat) begin
                    state_d = (w_burst_q == count_q - 16'd1) ? StWrB : StWrAw;
                end
            end
            StWrB: if (b_cnt_q == count_q) state_d = do_read_q ? StRd : StFin;
            StRd:  if (r_done_q == count_q && outst_q == 4'd0) state_d = StFin;
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from state.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StInit: busy = 1'b1;
            StWrAw: begin
                busy          = 1'b1;
                M_AXI_AWVALID = 1'b1;
                M_AXI_BREADY  = 1'b1;
            end
            StWrW: begin
                busy         = 1'b1;
                M_AXI_WVALID = 1'b1;
                M_AXI_BREADY = 1'b1;
            end
            StWrB: begin
                busy         = 1'b1;
                M_AXI_BREADY = 1'b1;
            end
            StRd: begin
                busy          = 1'b1;
                M_AXI_RREADY  = 1'b1;
                M_AXI_ARVALID = (ar_idx_q != count_q) && (outst_q < MaxOut);
            end
            StFin: done = 1'b1;
            default: ;
        endcase
    end

    // Run configuration, burst/beat trackers and error counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            len_q      <= 8'd0;
            count_q    <= 16'd0;
            do_write_q <= 1'b0;
            do_read_q  <= 1'b0;
            stride_q   <= '0;
            wr_addr_q  <= '0;
            w_beat_q   <= 8'd0;
            w_burst_q  <= 16'd0;
            b_cnt_q    <= 16'd0;
            ar_addr_q  <= '0;
            ar_idx_q   <= 16'd0;
            outst_q    <= 4'd0;
            r_addr_q   <= '0;
            r_beat_q   <= 8'd0;
            r_done_q   <= 16'd0;
            err_q      <= 16'd0;
        end else if (start_ok) begin
            len_q      <= burst_len;
            count_q    <= burst_count;
            do_write_q <= do_write;
            do_read_q  <= do_read;
            stride_q   <= (AW'(burst_len) + AW'(1)) << Size;
            wr_addr_q  <= base_addr;
            w_beat_q   <= 8'd0;
            w_burst_q  <= 16'd0;
            b_cnt_q    <= 16'd0;
            ar_addr_q  <= base_addr;
            ar_idx_q   <= 16'd0;
            outst_q    <= 4'd0;
            r_addr_q   <= base_addr;
            r_beat_q   <= 8'd0;
            r_done_q   <= 16'd0;
            err_q      <= 16'd0;
        end else begin
            // Bursts are contiguous, so the beat address simply keeps incrementing.
            if (w_hs) begin
                wr_addr_q <= wr_addr_q + BeatInc;
                if (w_last_beat) begin
                    w_beat_q  <= 8'd0;
                    w_burst_q <= w_burst_q + 16'd1;
                end else begin
                    w_beat_q <= w_beat_q + 8'd1;
                end
            end
            if (b_hs) b_cnt_q <= b_cnt_q + 16'd1;
            if (ar_hs) begin
                ar_idx_q  <= ar_idx_q + 16'd1;
                ar_addr_q <= ar_addr_q + stride_q;
            end
            if (ar_hs && !(r_last_hs && outst_q != 4'd0)) begin
                outst_q <= outst_q + 4'd1;
            end else if (!ar_hs && r_last_hs && outst_q != 4'd0) begin
                outst_q <= outst_q - 4'd1;
            end
            if (r_hs) begin
                r_addr_q <= r_addr_q + BeatInc;
                if (r_beat_q == len_q) begin
                    r_beat_q <= 8'd0;
                    r_done_q <= r_done_q + 16'd1;
                end else begin
                    r_beat_q <= r_beat_q + 8'd1;
                end
            end
            if (err_inc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
    end

`ifdef EXER_CYCLE_COUNT_EN
    logic [31:0] cyc_q;

    // Cycles spent busy since the last start; holds after done.
    always_ff @(posedge clk) begin
        if (!resetn)       cyc_q <= 32'd0;
        else if (start_ok) cyc_q <= 32'd0;
        else if (busy)     cyc_q <= cyc_q + 32'd1;
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = 32'd0;
`endif

endmodule
